// File: rtl/dp_ram_clr_if.sv
// Bus bundle for dp_ram_clr: clear control, port A read/write and port B read.
// The master side drives requests; the slave side is the RAM.
interface dp_ram_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                      clr;
    logic                      busy;
    logic                      ena;
    logic                      wena;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     data_in;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      enb;
    logic [ADDR_WIDTH-1:0]     addr_b;
    logic [DATA_WIDTH-1:0]     data_out_b;

    modport master (
        output clr, ena, wena, be, addr, data_in, enb, addr_b,
        input  busy, data_out, data_out_b
    );

    modport slave (
        input  clr, ena, wena, be, addr, data_in, enb, addr_b,
        output busy, data_out, data_out_b
    );
endinterface

// File: rtl/dp_ram_clr.sv
// Dual-port RAM (A: read/write with byte enables, B: read-only), registered reads,
// zeroed by a hardware sweep after every reset and on a clr pulse.
module dp_ram_clr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RD_MODE    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    dp_ram_clr_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NBYTE = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    a_rd, b_rd, a_wr;
    logic [DATA_WIDTH-1:0]   old_a, old_b, merged, new_a, new_b;

    assign old_a = mem[bus.addr];
    assign old_b = mem[bus.addr_b];

    always_comb begin
        merged = old_a;
        for (int i = 0; i < NBYTE; i++) begin
            if (bus.be[i]) merged[8*i +: 8] = bus.data_in[8*i +: 8];
        end
    end

    // Write-first mode forwards the merged word to both ports on a same-edge write.
    assign a_wr  = a_rd && bus.wena;
    assign new_a = (RD_MODE != 0) ? merged : old_a;
    assign new_b = ((RD_MODE != 0) && a_wr && (bus.addr_b == bus.addr)) ? merged : old_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments for all registered state, so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_addr  = bus.addr;
        mem_wdata = merged;
        a_rd      = 1'b0;
        b_rd      = 1'b0;
        unique case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
                if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                if (bus.clr) begin
                    state_nxt = CLEAR;
                end else begin
                    a_rd   = bus.ena;
                    b_rd   = bus.enb;
                    mem_we = bus.ena && bus.wena;
                end
            end
        endcase
    end

    assign bus.busy = (state == CLEAR);

    // NOTE: the array has no reset; zeroing is done by the sweep, which keeps
    // the memory mappable onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Read registers drop to zero while sweeping and on the edge that starts a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out   <= '0;
            bus.data_out_b <= '0;
        end else if (state == CLEAR || bus.clr) begin
            bus.data_out   <= '0;
            bus.data_out_b <= '0;
        end else begin
            if (a_rd) bus.data_out   <= new_a;
            if (b_rd) bus.data_out_b <= new_b;
        end
    end
endmodule

// File: tb/tb_dp_ram_clr.sv
// Scoreboard bench for dp_ram_clr: the driver queues expected read data per port,
// a negedge monitor pops and compares one cycle after each issued request.
module tb_dp_ram_clr;
    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int DEPTH   = 32;
    localparam int RD_MODE = 0;
    localparam bit WF      = (RD_MODE != 0);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dp_ram_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dp_ram_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_MODE(RD_MODE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        issue_a = 1'b0, issue_b = 1'b0;
    logic        va = 1'b0, vb = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Marks which edges carried a request whose result must be compared.
    always @(posedge clk) begin
        va <= issue_a;
        vb <= issue_b;
    end

    always @(negedge clk) begin
        if (va) begin
            if (qa.size() == 0) check("port A queue underflow", 32'd1, 32'd0);
            else                check("data_out", bus.data_out, qa.pop_front());
        end
        if (vb) begin
            if (qb.size() == 0) check("port B queue underflow", 32'd1, 32'd0);
            else                check("data_out_b", bus.data_out_b, qb.pop_front());
        end
    end

    task automatic idle();
        bus.clr = 1'b0; bus.ena = 1'b0; bus.wena = 1'b0; bus.be = '0;
        bus.addr = '0; bus.data_in = '0; bus.enb = 1'b0; bus.addr_b = '0;
        issue_a = 1'b0; issue_b = 1'b0;
    endtask

    task automatic step(input logic a_en, input logic a_we, input logic [3:0] a_be,
                        input logic [4:0] a_ad, input logic [31:0] din,
                        input logic b_en, input logic [4:0] b_ad,
                        input logic ca, input logic [31:0] ea,
                        input logic cb, input logic [31:0] eb,
                        input logic c = 1'b0);
        @(negedge clk);
        bus.clr = c; bus.ena = a_en; bus.wena = a_we; bus.be = a_be;
        bus.addr = a_ad; bus.data_in = din; bus.enb = b_en; bus.addr_b = b_ad;
        issue_a = ca; issue_b = cb;
        if (ca) qa.push_back(ea);
        if (cb) qb.push_back(eb);
        @(posedge clk);
    endtask

    // Runs DEPTH edges of a sweep while hammering both ports and pulsing clr;
    // none of it may take effect and busy must fall exactly after the last edge.
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            bus.ena = 1'b1; bus.wena = 1'b1; bus.be = '1; bus.addr = '0;
            bus.data_in = 32'hFFFF_FFFF; bus.enb = 1'b1; bus.addr_b = '0;
            bus.clr = (i >= 5 && i <= 10);
            issue_a = 1'b0; issue_b = 1'b0;
            @(posedge clk);
            #1;
            check({tag, " busy"}, 32'(bus.busy), 32'(i < DEPTH));
            check({tag, " data_out"}, bus.data_out, 32'd0);
            check({tag, " data_out_b"}, bus.data_out_b, 32'd0);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < DEPTH; i++)
            step(1, 0, 4'h0, 5'(i), 0, 1, 5'(DEPTH - 1 - i), 1, 32'd0, 1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        #23;
        check("reset busy", 32'(bus.busy), 32'd1);
        check("reset data_out", bus.data_out, 32'd0);
        check("reset data_out_b", bus.data_out_b, 32'd0);

        // Reset again at sweep count 10; the sweep must restart from scratch.
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            check("partial sweep busy", 32'(bus.busy), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid-sweep reset busy", 32'(bus.busy), 32'd1);
        check("mid-sweep reset data_out", bus.data_out, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        sweep_check("reset sweep");
        read_all_zero();

        // Fill addr i with i+1.
        for (int i = 0; i < DEPTH; i++)
            step(1, 1, 4'hF, 5'(i), 32'(i + 1), 0, 0, 1, WF ? 32'(i + 1) : 32'd0, 0, 0);

        // Read back on both ports; a following ena=0/enb=0 cycle must hold the outputs.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 4'h0, 5'(i), 0, 1, 5'(i), 1, 32'(i + 1), 1, 32'(i + 1));
            step(0, 0, 4'h0, 5'(i + 3), 0, 0, 5'(i + 5), 1, 32'(i + 1), 1, 32'(i + 1));
        end

        // Byte enables on addr 3 (holds 4); second write also collides with port B.
        step(1, 1, 4'hF, 3, 32'hAABB_CCDD, 0, 0, 1, WF ? 32'hAABB_CCDD : 32'd4, 0, 0);
        step(1, 1, 4'h5, 3, 32'h1122_3344, 1, 3,
             1, WF ? 32'hAA22_CC44 : 32'hAABB_CCDD, 1, WF ? 32'hAA22_CC44 : 32'hAABB_CCDD);
        step(1, 1, 4'h0, 3, 32'hFFFF_FFFF, 0, 0, 1, 32'hAA22_CC44, 0, 0);
        step(1, 0, 4'h0, 3, 0, 1, 3, 1, 32'hAA22_CC44, 1, 32'hAA22_CC44);

        // Collision on addr 7, then independent different-address traffic.
        step(1, 1, 4'hF, 7, 32'h5, 0, 0, 1, WF ? 32'h5 : 32'h8, 0, 0);
        step(1, 1, 4'hF, 7, 32'h9, 1, 7, 1, WF ? 32'h9 : 32'h5, 1, WF ? 32'h9 : 32'h5);
        step(0, 0, 4'h0, 0, 0, 1, 7, 0, 0, 1, 32'h9);
        step(1, 1, 4'hF, 8, 32'h77, 1, 9, 1, WF ? 32'h77 : 32'h9, 1, 32'd10);
        step(1, 0, 4'h0, 8, 0, 0, 0, 1, 32'h77, 0, 0);

        // clr with a concurrent write to addr 2; the write must be dropped.
        step(1, 1, 4'hF, 2, 32'h1234, 1, 2, 0, 0, 0, 0, 1);
        #1;
        check("clr edge busy", 32'(bus.busy), 32'd1);
        check("clr edge data_out", bus.data_out, 32'd0);
        sweep_check("clr sweep");
        read_all_zero();

        // Asynchronous reset while outputs hold non-zero data.
        step(1, 1, 4'hF, 4, 32'hCAFE, 0, 0, 0, 0, 0, 0);
        step(1, 0, 4'h0, 4, 0, 1, 4, 1, 32'hCAFE, 1, 32'hCAFE);
        @(negedge clk);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(bus.busy), 32'd1);
        check("async reset data_out", bus.data_out, 32'd0);
        check("async reset data_out_b", bus.data_out_b, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        sweep_check("reset2 sweep");
        step(1, 0, 4'h0, 4, 0, 1, 4, 1, 32'd0, 1, 32'd0);

        @(negedge clk);
        idle();
        @(negedge clk);
        check("port A queue drained", 32'(qa.size()), 32'd0);
        check("port B queue drained", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_ram_clr.md
# dp_ram_clr

Parametrised synchronous RAM: one read/write port (A) with byte enables, one independent read-only port (B), and registered read data with one-cycle latency. Memory is zeroed in hardware by a sweep state machine after every reset and on request, with `busy` flagging the sweep. Drop-in successor to the fixed 32x32 single-port `ram`, used as register-file/scratch storage in the datapath.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 5: address width; depth DEPTH = 2**ADDR_WIDTH.
- `RD_MODE`, 0: 0 = read-first (old data on write/collision), 1 = write-first (new merged data).
- `clk`  input  1: single clock, all state on rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `clr`  input  1: pulse to re-zero the whole memory.
- `busy`  output  1: high while clear sweep runs; ports ignored.
- `ena`  input  1: port A enable.
- `wena`  input  1: port A write enable (1 = write, 0 = read); ignored if `ena`=0.
- `be`  input  DATA_WIDTH/8: port A byte write enables, bit i covers bits [8i+7:8i].
- `addr`  input  ADDR_WIDTH: port A address.
- `data_in`  input  DATA_WIDTH: port A write data.
- `data_out`  output  DATA_WIDTH: port A registered read data.
- `enb`  input  1: port B read enable.
- `addr_b`  input  ADDR_WIDTH: port B address.
- `data_out_b`  output  DATA_WIDTH: port B registered read data.

## Operation
- FSM states: CLEAR, READY. `rst_n`=0 forces CLEAR, sweep counter 0, `busy`=1, `data_out`=0, `data_out_b`=0. Memory array itself has no reset.
- CLEAR: each edge writes 0 to mem[cnt], cnt+1. On edge writing cnt=DEPTH-1 -> READY, `busy`<=0, cnt<=0 (no wrap re-sweep).
- READY + `clr`=1 -> CLEAR at that edge; any port A/B request on that same edge is discarded. `clr` during CLEAR ignored (sweep not restarted).
- In CLEAR: `ena`, `enb` ignored, no user writes, `data_out`/`data_out_b` forced to 0.
- READY, `ena`=1,`wena`=1: bytes with `be[i]`=1 take `data_in`, others unchanged. `be`=0 -> no change. `data_out` <= old word (RD_MODE=0) or merged new word (RD_MODE=1).
- READY, `ena`=1,`wena`=0: `data_out` <= mem[`addr`].
- READY, `enb`=1: `data_out_b` <= mem[`addr_b`].
- `ena`=0 / `enb`=0: corresponding output holds last value.
- Collision (A write, B read, same address, same edge): `data_out_b` gets old word (RD_MODE=0) or merged new word (RD_MODE=1). Different addresses: independent.
- Addresses are full-range; no out-of-range case.

## Timing
- Read latency 1 edge on both ports: address sampled at edge N, data valid after edge N.
- Write visible to reads at edge N+1 (plus same-edge per RD_MODE).
- After `rst_n` rises: `busy`=1 for exactly DEPTH rising edges; first accepted access is at edge DEPTH+1.
- `clr` sampled at edge N in READY: `busy`=1 after N, low after edge N+DEPTH.
- `rst_n` asserted mid-sweep or mid-write: outputs/`busy` react immediately (async); sweep restarts from 0 on release; words already written keep their value until swept.

## Test plan
- Reset release, DEPTH=32: `busy`=1 for 32 edges then 0; reads of addr 0..31 return 0; `data_out`=0 throughout reset.
- Write addr i = i+1 for i=0..31 (`be`=all ones), then read port A 0..31 -> data_out = 1..32 one cycle after each address; `ena`=0 during reads -> data_out holds.
- Byte enables: write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read 0xAA22CC44.
- Collision addr 7 holding 0x5, A writes 0x9, B reads 7 same edge -> data_out_b=0x5 with RD_MODE=0, 0x9 with RD_MODE=1; A write-cycle data_out same values.
- Pulse `clr` after filling memory, with concurrent write to addr 2 -> write discarded, `busy` high 32 edges, all words read 0; requests during `busy` ignored.
- Assert `rst_n`=0 at sweep count 10 -> `busy` stays 1, outputs 0; after release full 32-edge sweep completes before first access is accepted.
